// File: rtl/ctrl_pkg.sv
// Shared decode constants, opcode classification and the registered control bundle
// for the RV32I-subset control unit.
package ctrl_pkg;

    localparam int ALU_W = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } op_class_t;

    typedef struct packed {
        logic             reg_write;
        logic [ALU_W-1:0] alu_control;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             branch;
        logic             branch_ne;
        logic [1:0]       mem_size;
        logic             illegal;
    } ctrl_t;

    function automatic op_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            default:   return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU operation select and legality check from opcode class plus funct3/funct7.
// SUB and SRL/SRLI are only legal when CONTROL_UNIT_SUB_SRL_EN is defined.
module alu_decoder
    import ctrl_pkg::*;
(
    input  op_class_t        i_op_class,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    output logic [ALU_W-1:0] o_alu_control,
    output logic             o_illegal
);

`ifdef CONTROL_UNIT_SUB_SRL_EN
    localparam bit SUB_SRL_EN = 1'b1;
`else
    localparam bit SUB_SRL_EN = 1'b0;
`endif

    logic [ALU_W-1:0] w_alu;
    logic             w_bad;
    logic             w_f7_zero;
    logic             w_f7_alt;

    assign w_f7_zero = (i_funct7 == F7_ZERO);
    assign w_f7_alt  = (i_funct7 == F7_ALT);

    always_comb begin
        w_alu = ALU_AND;
        w_bad = 1'b0;
        case (i_op_class)
            CLS_R: begin
                case (i_funct3)
                    3'b000: begin
                        if (w_f7_zero)                    w_alu = ALU_ADD;
                        else if (w_f7_alt && SUB_SRL_EN)  w_alu = ALU_SUB;
                        else                              w_bad = 1'b1;
                    end
                    3'b110: begin w_alu = ALU_OR;  w_bad = !w_f7_zero; end
                    3'b111: begin w_alu = ALU_AND; w_bad = !w_f7_zero; end
                    3'b100: begin w_alu = ALU_XOR; w_bad = !w_f7_zero; end
                    3'b001: begin w_alu = ALU_SLL; w_bad = !w_f7_zero; end
                    3'b101: begin w_alu = ALU_SRL; w_bad = !(w_f7_zero && SUB_SRL_EN); end
                    default: w_bad = 1'b1;
                endcase
            end
            CLS_I: begin
                // funct7 only matters for the shift-immediate forms
                case (i_funct3)
                    3'b000: w_alu = ALU_ADD;
                    3'b110: w_alu = ALU_OR;
                    3'b111: w_alu = ALU_AND;
                    3'b100: w_alu = ALU_XOR;
                    3'b001: begin w_alu = ALU_SLL; w_bad = !w_f7_zero; end
                    3'b101: begin w_alu = ALU_SRL; w_bad = !(w_f7_zero && SUB_SRL_EN); end
                    default: w_bad = 1'b1;
                endcase
            end
            CLS_LOAD, CLS_STORE: begin
                w_alu = ALU_ADD;
                w_bad = !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010);
            end
            CLS_BRANCH: begin
                w_alu = ALU_SUB;
                w_bad = !(i_funct3 == 3'b000 || i_funct3 == 3'b001);
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign o_alu_control = w_bad ? ALU_AND : w_alu;
    assign o_illegal     = w_bad;

endmodule

// File: rtl/control_unit.sv
// Main decoder for the RV32I-subset datapath: opcode-class decode plus one output register.
// Optional SUB/SRL decode is enabled by defining CONTROL_UNIT_SUB_SRL_EN.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = ALU_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    output logic                  reg_write,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  branch,
    output logic                  branch_ne,
    output logic [1:0]            mem_size,
    output logic                  illegal
);

    op_class_t        w_class;
    logic [ALU_W-1:0] w_alu_control;
    logic             w_illegal;
    ctrl_t            w_ctrl;
    ctrl_t            r_ctrl;

    assign w_class = classify(opcode);

    alu_decoder u_alu_decoder (
        .i_op_class    (w_class),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .o_alu_control (w_alu_control),
        .o_illegal     (w_illegal)
    );

    always_comb begin
        w_ctrl             = '0;
        w_ctrl.alu_control = w_alu_control;
        case (w_class)
            CLS_R: begin
                w_ctrl.reg_write = 1'b1;
            end
            CLS_I: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
            end
            CLS_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.mem_size   = funct3[1:0];
            end
            CLS_STORE: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.mem_size  = funct3[1:0];
            end
            CLS_BRANCH: begin
                w_ctrl.branch    = 1'b1;
                w_ctrl.branch_ne = (funct3 == 3'b001);
            end
            default: ;
        endcase
        // an illegal encoding must never leak any enable downstream
        if (w_illegal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ctrl <= '0;
        else        r_ctrl <= w_ctrl;
    end

    assign reg_write   = r_ctrl.reg_write;
    assign alu_control = ALU_CTRL_W'(r_ctrl.alu_control);
    assign alu_src     = r_ctrl.alu_src;
    assign mem_read    = r_ctrl.mem_read;
    assign mem_write   = r_ctrl.mem_write;
    assign mem_to_reg  = r_ctrl.mem_to_reg;
    assign branch      = r_ctrl.branch;
    assign branch_ne   = r_ctrl.branch_ne;
    assign mem_size    = r_ctrl.mem_size;
    assign illegal     = r_ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; honours CONTROL_UNIT_SUB_SRL_EN
// for the SUB / SRL expectations.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       reg_write;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_ne;
    logic [1:0] mem_size;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    control_unit #(.ALU_CTRL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .reg_write   (reg_write),
        .alu_control (alu_control),
        .alu_src     (alu_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .mem_size    (mem_size),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: reg_write, alu_control, alu_src, mem_read, mem_write,
    // mem_to_reg, branch, branch_ne, mem_size, illegal
    function automatic logic [14:0] exp_vec(input logic rw, input logic [3:0] alu,
                                            input logic src, input logic mr, input logic mw,
                                            input logic m2r, input logic br, input logic bne,
                                            input logic [1:0] sz, input logic ill);
        return {rw, alu, src, mr, mw, m2r, br, bne, sz, ill};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {reg_write, alu_control, alu_src, mem_read, mem_write,
                mem_to_reg, branch, branch_ne, mem_size, illegal};
    endfunction

    localparam logic [14:0] E_ILLEGAL = 15'b0_0000_0_0_0_0_0_0_00_1;

    task automatic check(input string tag, input logic [14:0] expected);
        logic [14:0] observed;
        observed = obs_vec();
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 15'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(7'b0110011, 3'b000, 7'b0000000);
        check("add", exp_vec(1, 4'b0010, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        // outputs must hold until the next edge
        opcode = 7'b1111111;
        #2;
        check("latency_hold", exp_vec(1, 4'b0010, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        @(negedge clk);

        apply(7'b0110011, 3'b110, 7'b0000000);
        check("or", exp_vec(1, 4'b0001, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b0010011, 3'b111, 7'b0000000);
        check("andi", exp_vec(1, 4'b0000, 1, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b0110011, 3'b001, 7'b0000000);
        check("sll", exp_vec(1, 4'b0011, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b0110011, 3'b100, 7'b0000000);
        check("xor", exp_vec(1, 4'b0101, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b1100011, 3'b001, 7'b1010101);
        check("bne", exp_vec(0, 4'b0110, 0, 0, 0, 0, 1, 1, 2'b00, 0));

        apply(7'b1100011, 3'b000, 7'b0000000);
        check("beq", exp_vec(0, 4'b0110, 0, 0, 0, 0, 1, 0, 2'b00, 0));

        apply(7'b0100011, 3'b001, 7'b0000000);
        check("sh", exp_vec(0, 4'b0010, 1, 0, 1, 0, 0, 0, 2'b01, 0));

        apply(7'b0100011, 3'b000, 7'b1111111);
        check("sb_f7_ignored", exp_vec(0, 4'b0010, 1, 0, 1, 0, 0, 0, 2'b00, 0));

        apply(7'b0000011, 3'b001, 7'b0000000);
        check("lh", exp_vec(1, 4'b0010, 1, 1, 0, 1, 0, 0, 2'b01, 0));

        apply(7'b0000011, 3'b010, 7'b0100000);
        check("lw", exp_vec(1, 4'b0010, 1, 1, 0, 1, 0, 0, 2'b10, 0));

        apply(7'b1111111, 3'b000, 7'b0000000);
        check("bad_opcode", E_ILLEGAL);

        apply(7'b0110011, 3'b110, 7'b0000001);
        check("r_bad_f7", E_ILLEGAL);

        apply(7'b0000011, 3'b011, 7'b0000000);
        check("load_bad_f3", E_ILLEGAL);

        apply(7'b1100011, 3'b100, 7'b0000000);
        check("branch_bad_f3", E_ILLEGAL);

        apply(7'b0010011, 3'b000, 7'b0100000);
        check("addi_f7_ignored", exp_vec(1, 4'b0010, 1, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b0010011, 3'b001, 7'b0100000);
        check("slli_bad_f7", E_ILLEGAL);

        apply(7'b0010011, 3'b010, 7'b0000000);
        check("slti_unsupported", E_ILLEGAL);

`ifdef CONTROL_UNIT_SUB_SRL_EN
        apply(7'b0110011, 3'b000, 7'b0100000);
        check("sub", exp_vec(1, 4'b0110, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b0010011, 3'b101, 7'b0000000);
        check("srli", exp_vec(1, 4'b0100, 1, 0, 0, 0, 0, 0, 2'b00, 0));

        apply(7'b0110011, 3'b101, 7'b0000000);
        check("srl", exp_vec(1, 4'b0100, 0, 0, 0, 0, 0, 0, 2'b00, 0));
`else
        apply(7'b0110011, 3'b000, 7'b0100000);
        check("sub_disabled", E_ILLEGAL);

        apply(7'b0010011, 3'b101, 7'b0000000);
        check("srli_disabled", E_ILLEGAL);

        apply(7'b0110011, 3'b101, 7'b0000000);
        check("srl_disabled", E_ILLEGAL);
`endif

        // async reset between edges with an R-type on the inputs
        apply(7'b0110011, 3'b000, 7'b0000000);
        check("add_before_reset", exp_vec(1, 4'b0010, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 15'd0);
        @(posedge clk);
        #1;
        check("reset_held", 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(7'b0110011, 3'b111, 7'b0000000);
        check("and_after_reset", exp_vec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
